// File: rtl/sw_bounce_gen.sv
// Switch-bounce stimulus: chatters sw_out pseudo-randomly for BOUNCE_TICKS*2^N cycles after a level change, then settles.
// Optional SW_BOUNCE_RELEASE_EN: when defined, falling edges bounce too; otherwise falls settle in one cycle.
module sw_bounce_gen #(
    parameter int          N            = 20,
    parameter int          M            = 12,
    parameter int          BOUNCE_TICKS = 3,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic clk,
    input  logic reset,
    input  logic level_in,
    output logic sw_out,
    output logic busy,
    output logic done
);

    typedef enum logic {IDLE, BOUNCE} state_t;

    localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [7:0]  LAST_TICK = 8'(BOUNCE_TICKS - 1);
    localparam logic [N-1:0] CNT_MAX  = {N{1'b1}};

    state_t         state_q, state_d;
    logic           target_q, target_d;
    logic [N-1:0]   cnt_q, cnt_d;
    logic [7:0]     tcnt_q, tcnt_d;
    logic [15:0]    lfsr_q, lfsr_d;
    logic           sw_q, sw_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           may_bounce;

`ifdef SW_BOUNCE_RELEASE_EN
    assign may_bounce = 1'b1;
`else
    // Only rising commands bounce; a fall settles (or aborts a bounce) immediately.
    assign may_bounce = level_in;
`endif

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        tcnt_d   = tcnt_q;
        sw_d     = sw_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        lfsr_d   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

        case (state_q)
            IDLE: begin
                sw_d   = target_q;
                busy_d = 1'b0;
                if (level_in != target_q) begin
                    target_d = level_in;
                    if (may_bounce) begin
                        cnt_d   = '0;
                        tcnt_d  = '0;
                        busy_d  = 1'b1;
                        sw_d    = lfsr_q[0];
                        state_d = BOUNCE;
                    end else begin
                        sw_d   = level_in;
                        done_d = 1'b1;
                    end
                end
            end
            BOUNCE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q[M-1:0] == '0) begin
                    sw_d = lfsr_q[0];
                end
                if (cnt_q == CNT_MAX) begin
                    tcnt_d = tcnt_q + 8'd1;
                end
                if (level_in != target_q) begin
                    target_d = level_in;
                    cnt_d    = '0;
                    tcnt_d   = '0;
                    if (!may_bounce) begin
                        sw_d    = level_in;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else if (cnt_q == CNT_MAX && tcnt_q == LAST_TICK) begin
                    cnt_d   = '0;
                    tcnt_d  = '0;
                    sw_d    = target_q;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            target_q <= 1'b0;
            cnt_q    <= '0;
            tcnt_q   <= '0;
            lfsr_q   <= SEED_EFF;
            sw_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            tcnt_q   <= tcnt_d;
            lfsr_q   <= lfsr_d;
            sw_q     <= sw_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign sw_out = sw_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_sw_bounce_gen.sv
// Directed bench for sw_bounce_gen with N=4, M=2, BOUNCE_TICKS=3 (48-cycle bounce).
module tb_sw_bounce_gen;

    logic clk;
    logic reset;
    logic level_in;
    logic sw_out;
    logic busy;
    logic done;

    int checks   = 0;
    int failures = 0;

    localparam int CAP = 60;
    logic cap_b [0:CAP-1];
    logic cap_d [0:CAP-1];
    logic cap_s [0:CAP-1];
    logic seq_a [0:CAP-1];

    sw_bounce_gen #(.N(4), .M(2), .BOUNCE_TICKS(3), .SEED(16'hACE1)) dut (
        .clk      (clk),
        .reset    (reset),
        .level_in (level_in),
        .sw_out   (sw_out),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic capture();
        for (int k = 0; k < CAP; k++) begin
            step();
            cap_b[k] = busy;
            cap_d[k] = done;
            cap_s[k] = sw_out;
        end
    endtask

    // Expect a full 48-cycle bounce starting at capture index 0, settling to exp_final at index 48.
    task automatic check_bounce(input string tag, input logic exp_final);
        int nbusy, ndone, nboth, bad_chg, toggles;
        nbusy = 0; ndone = 0; nboth = 0; bad_chg = 0; toggles = 0;
        for (int k = 0; k < CAP; k++) begin
            nbusy += int'(cap_b[k]);
            ndone += int'(cap_d[k]);
            nboth += int'(cap_b[k] & cap_d[k]);
            if (k >= 1 && k <= 47 && cap_s[k] != cap_s[k-1]) begin
                toggles++;
                if (((k - 1) % 4) != 0) bad_chg++;
            end
        end
        chk({tag, "_busy_first"}, 32'(cap_b[0]), 32'd1);
        chk({tag, "_busy_last"},  32'(cap_b[47]), 32'd1);
        chk({tag, "_busy_end"},   32'(cap_b[48]), 32'd0);
        chk({tag, "_busy_cnt"},   32'(nbusy), 32'd48);
        chk({tag, "_done_at_end"}, 32'(cap_d[48]), 32'd1);
        chk({tag, "_done_cnt"},   32'(ndone), 32'd1);
        chk({tag, "_done_busy_overlap"}, 32'(nboth), 32'd0);
        chk({tag, "_sw_final"},   32'(cap_s[48]), 32'(exp_final));
        chk({tag, "_sw_held"},    32'(cap_s[59]), 32'(exp_final));
        chk({tag, "_chatter_grid"}, 32'(bad_chg), 32'd0);
        chk({tag, "_chatter_toggles"}, 32'(toggles > 0), 32'd1);
    endtask

    // Rise, hold for 'hold' edges, then fall while bouncing.
    task automatic retarget_test(input string tag, input int hold);
        int early_done;
        early_done = 0;
        level_in = 1'b1;
        for (int k = 0; k < hold; k++) begin
            step();
            early_done += int'(done);
        end
        chk({tag, "_busy_before_fall"}, 32'(busy), 32'd1);
        level_in = 1'b0;
        capture();
        chk({tag, "_no_early_done"}, 32'(early_done), 32'd0);
`ifdef SW_BOUNCE_RELEASE_EN
        check_bounce(tag, 1'b0);
`else
        chk({tag, "_abort_busy"}, 32'(cap_b[0]), 32'd0);
        chk({tag, "_abort_sw"},   32'(cap_s[0]), 32'd0);
        chk({tag, "_abort_done"}, 32'(cap_d[0]), 32'd1);
        chk({tag, "_abort_done_once"}, 32'(cap_d[1]), 32'd0);
        chk({tag, "_abort_stays_idle"}, 32'(cap_b[30]), 32'd0);
`endif
    endtask

    task automatic record_run();
        reset = 1'b0;
        level_in = 1'b0;
        #7;
        reset = 1'b1;
        step();
        step();
        step();
        level_in = 1'b1;
        capture();
        level_in = 1'b0;
    endtask

    initial begin
        int nz;
        int diffs;
        reset = 1'b0;
        level_in = 1'b0;
        #12;
        chk("rst_sw",   32'(sw_out), 32'd0);
        chk("rst_busy", 32'(busy),   32'd0);
        chk("rst_done", 32'(done),   32'd0);
        @(negedge clk);
        reset = 1'b1;
        nz = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            nz += int'(sw_out) + int'(busy) + int'(done);
        end
        chk("idle_quiet", 32'(nz), 32'd0);

        // Rising bounce
        level_in = 1'b1;
        capture();
        check_bounce("rise", 1'b1);

        // Falling command from settled high
        level_in = 1'b0;
        capture();
`ifdef SW_BOUNCE_RELEASE_EN
        check_bounce("fall", 1'b0);
`else
        chk("fall_busy", 32'(cap_b[0]), 32'd0);
        chk("fall_sw",   32'(cap_s[0]), 32'd0);
        chk("fall_done", 32'(cap_d[0]), 32'd1);
        chk("fall_done_once", 32'(cap_d[1]), 32'd0);
`endif

        retarget_test("retarget20", 20);
        retarget_test("pulse5", 5);

        // Asynchronous reset mid-bounce
        level_in = 1'b1;
        for (int k = 0; k < 30; k++) step();
        chk("midrst_busy_before", 32'(busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy),   32'd0);
        chk("midrst_sw",   32'(sw_out), 32'd0);
        chk("midrst_done", 32'(done),   32'd0);
        level_in = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        nz = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            nz += int'(done) + int'(busy);
        end
        chk("midrst_no_done", 32'(nz), 32'd0);
        level_in = 1'b1;
        capture();
        check_bounce("after_rst", 1'b1);

        // Determinism from seed
        record_run();
        for (int k = 0; k < CAP; k++) seq_a[k] = cap_s[k];
        record_run();
        diffs = 0;
        for (int k = 0; k < CAP; k++) diffs += int'(seq_a[k] != cap_s[k]);
        chk("determinism", 32'(diffs), 32'd0);
        check_bounce("det_run", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/sw_bounce_gen.md
Name: sw_bounce_gen

Overview:
- Synthesisable stimulus source that emulates a mechanical switch.
- Takes a clean commanded level and drives a switch-like output that chatters pseudo-randomly for a fixed, programmable interval, then settles to the commanded level.
- Transmit-side counterpart of our switch debouncer. Used for on-board self-test and hardware-in-loop checks of debounce timing.

Parameters:
- N, 20: slow-tick period exponent. One slow tick = 2^N clk cycles (10 ms at 100 MHz).
- M, 12: chatter exponent. The output may change every 2^M cycles during bounce. Must satisfy 1 <= M < N.
- BOUNCE_TICKS, 3: bounce duration in slow ticks. Range 1..255.
- SEED, 16'hACE1: LFSR reset value. A value of 0 is replaced by 16'h0001.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- level_in  input  1  clean commanded switch level; synchronous to clk
- sw_out  output  1  emulated switch contact (registered)
- busy  output  1  high while bouncing (registered)
- done  output  1  one-cycle pulse when sw_out has settled to a new level (registered)

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, sw_out=0, busy=0, done=0, target=0, cnt=0, tcnt=0, lfsr=SEED.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1. Advances every clk, free-running in every state. The chatter bit is lfsr[0].
- Counters:
  - cnt: N bits, cycle counter within a slow tick.
  - tcnt: 8 bits, slow ticks elapsed.
  - Both are cleared when BOUNCE is entered.
- State IDLE:
  - busy=0, sw_out=target.
  - If level_in != target at a clk edge: target<=level_in, cnt<=0, tcnt<=0, busy<=1, next state BOUNCE.
- State BOUNCE:
  - cnt increments every cycle.
  - When cnt[M-1:0]==0 (including cnt=0), sw_out<=lfsr[0]. Otherwise sw_out holds.
  - When cnt==2^N-1: cnt wraps to 0 and tcnt increments.
  - Termination: when tcnt==BOUNCE_TICKS-1 and cnt==2^N-1, at the next edge sw_out<=target, busy<=0, done<=1, next state IDLE.
  - busy is therefore high for exactly BOUNCE_TICKS*2^N cycles.
- Retarget mid-bounce: if level_in != target in BOUNCE, then target<=level_in, cnt<=0, tcnt<=0. Bounce restarts for a full duration and done is not pulsed. This takes priority over termination in the same cycle.
- Level returns to target mid-bounce: no effect; the bounce runs to completion.
- done:
  - High for exactly one cycle after each settle; 0 otherwise.
  - Never asserted together with busy=1 in the same cycle.
- Reset mid-bounce: immediate return to the reset values, with no done pulse.
- Latency: a level_in change in IDLE yields busy=1 on the next edge. The first chatter sample is also driven on that edge.

Optional Feature:
- Macro: SW_BOUNCE_RELEASE_EN.
- Defined: both rising (0->1) and falling (1->0) commanded transitions bounce, as described above.
- Undefined: only rising transitions bounce. In IDLE, a falling level_in gives, at the next edge, sw_out<=0, target<=0, done<=1, with busy staying 0.
- Undefined, falling level_in during a rising bounce: abort the bounce. Next edge: sw_out<=0, target<=0, busy<=0, done<=1.

Test Plan (all with N=4, M=2, BOUNCE_TICKS=3, SEED=16'hACE1):
1. Hold reset=0, then release -> sw_out=0, busy=0, done=0. Holding level_in=0 for 100 cycles leaves all outputs unchanged.
2. level_in 0->1 at cycle t:
   - busy=1 from t+1 through t+48, 0 at t+49.
   - sw_out=1 and done=1 at t+49 only.
   - sw_out changes only at cnt multiples of 4 and toggles at least once in the window.
3. Mid-bounce retarget: level_in 0->1, then 1->0 after 20 cycles, with macro defined -> busy stays high a further 48 cycles from the retarget, no done at the original end, final sw_out=0.
4. level_in pulse 0->1->0 of 5 cycles with macro undefined -> bounce aborts. At the edge after the fall: busy=0, sw_out=0, done=1.
5. Assert reset=0 at cycle 30 of a bounce -> sw_out=0 and busy=0 asynchronously, no done. A subsequent 0->1 gives a full 48-cycle bounce.
6. Two runs from reset with identical stimulus -> identical cycle-by-cycle sw_out sequences (determinism from SEED).
